// File: rtl/alu_sig_bist_ctrl.sv
// Runtime LFSR/MISR signature BIST controller for an ALU datapath with an APB register bank.
// Optional build macro ALU_SIG_BIST_FAULT_INJECT_EN adds sim_fault_inject_i to flip result bit 0 while running.
module alu_sig_bist_ctrl #(
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    NUM_OPS         = 4,
  parameter int                    PATTERNS_PER_OP = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY       = 32'h8020_0003
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  core_sleep_i,
  output logic                  bist_active_o,
  output logic [DATA_WIDTH-1:0] bist_operand_a_o,
  output logic [DATA_WIDTH-1:0] bist_operand_b_o,
  output logic [3:0]            bist_op_sel_o,
  input  logic [DATA_WIDTH-1:0] dut_result_i,
`ifdef ALU_SIG_BIST_FAULT_INJECT_EN
  input  logic                  sim_fault_inject_i,
`endif
  input  logic [31:0]           paddr_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  error_irq_o
);

  localparam int         HALF     = DATA_WIDTH / 2;
  localparam logic [7:0] PAT_LAST = 8'(PATTERNS_PER_OP - 1);
  localparam logic [3:0] OP_LAST  = 4'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  en_q, en_d;
  logic                  auto_q, auto_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] golden_q, golden_d;
  logic [DATA_WIDTH-1:0] last_sig_q, last_sig_d;
  logic [DATA_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] misr_q, misr_d;
  logic [7:0]            pat_cnt_q, pat_cnt_d;
  logic [3:0]            op_cnt_q, op_cnt_d;
  logic [7:0]            count_q, count_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  aborted_q, aborted_d;
  logic                  irq_q, irq_d;
  logic [31:0]           prdata_q, prdata_d;

  logic                  wr_s, wr_ctrl_s, start_s, en_off_s, irq_clr_s;
  logic                  load_s, absorb_s, abort_s, check_s, accept_s;
  logic                  last_s, match_s;
  logic [DATA_WIDTH-1:0] absorb_data_s, lfsr_next_s, misr_next_s;
  logic [31:0]           rdata_s, status_s;

  assign wr_s      = psel_i & penable_i & pwrite_i;
  assign wr_ctrl_s = wr_s & (paddr_i == 32'h0000_0000);
  assign start_s   = wr_ctrl_s & pwdata_i[1] & pwdata_i[0];
  assign en_off_s  = wr_ctrl_s & ~pwdata_i[0];
  assign irq_clr_s = wr_ctrl_s & pwdata_i[2];

`ifdef ALU_SIG_BIST_FAULT_INJECT_EN
  assign absorb_data_s = dut_result_i ^ {{(DATA_WIDTH-1){1'b0}}, sim_fault_inject_i};
`else
  assign absorb_data_s = dut_result_i;
`endif

  // LFSR and MISR share the same left-shifting Galois feedback.
  assign lfsr_next_s = {lfsr_q[DATA_WIDTH-2:0], 1'b0} ^ (lfsr_q[DATA_WIDTH-1] ? LFSR_POLY : {DATA_WIDTH{1'b0}});
  assign misr_next_s = {misr_q[DATA_WIDTH-2:0], 1'b0} ^ (misr_q[DATA_WIDTH-1] ? LFSR_POLY : {DATA_WIDTH{1'b0}})
                       ^ absorb_data_s;
  assign last_s      = (pat_cnt_q == PAT_LAST) && (op_cnt_q == OP_LAST);
  assign match_s     = (misr_q == golden_q);

  assign bist_active_o    = (state_q == RUN) & core_sleep_i;
  assign bist_operand_a_o = lfsr_q;
  assign bist_operand_b_o = {lfsr_q[DATA_WIDTH-HALF-1:0], lfsr_q[DATA_WIDTH-1:DATA_WIDTH-HALF]};
  assign bist_op_sel_o    = (state_q == RUN) ? op_cnt_q : 4'd0;
  assign prdata_o         = prdata_q;
  assign pready_o         = 1'b1;
  assign error_irq_o      = irq_q;

  // Session sequencing; clearing EN overrides every state.
  always_comb begin
    state_d  = state_q;
    load_s   = 1'b0;
    absorb_s = 1'b0;
    abort_s  = 1'b0;
    check_s  = 1'b0;
    accept_s = 1'b0;
    if (en_off_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_d  = ARMED;
            accept_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        ARMED: begin
          if (core_sleep_i) begin
            state_d = RUN;
            load_s  = 1'b1;
          end else begin
            state_d = ARMED;
          end
        end
        RUN: begin
          if (!core_sleep_i) begin
            state_d = ARMED;
            abort_s = 1'b1;
          end else begin
            absorb_s = 1'b1;
            state_d  = last_s ? CHECK : RUN;
          end
        end
        CHECK: begin
          check_s = 1'b1;
          state_d = auto_q ? ARMED : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Register-bank, datapath and flag next-state.
  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    seed_d     = seed_q;
    golden_d   = golden_q;
    last_sig_d = last_sig_q;
    lfsr_d     = lfsr_q;
    misr_d     = misr_q;
    pat_cnt_d  = pat_cnt_q;
    op_cnt_d   = op_cnt_q;
    count_d    = count_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    aborted_d  = aborted_q;
    irq_d      = irq_q;
    if (wr_ctrl_s) begin
      en_d   = pwdata_i[0];
      auto_d = pwdata_i[3];
    end else begin
      en_d   = en_q;
    end
    if (wr_s && (paddr_i == 32'h0000_0008)) begin
      seed_d = pwdata_i[DATA_WIDTH-1:0];
    end else begin
      seed_d = seed_q;
    end
    if (wr_s && (paddr_i == 32'h0000_000C)) begin
      golden_d = pwdata_i[DATA_WIDTH-1:0];
    end else begin
      golden_d = golden_q;
    end
    if (load_s) begin
      lfsr_d    = (seed_q == {DATA_WIDTH{1'b0}}) ? {{(DATA_WIDTH-1){1'b0}}, 1'b1} : seed_q;
      misr_d    = {DATA_WIDTH{1'b1}};
      pat_cnt_d = 8'd0;
      op_cnt_d  = 4'd0;
    end else if (absorb_s) begin
      lfsr_d = lfsr_next_s;
      misr_d = misr_next_s;
      if (pat_cnt_q == PAT_LAST) begin
        pat_cnt_d = 8'd0;
        op_cnt_d  = op_cnt_q + 4'd1;
      end else begin
        pat_cnt_d = pat_cnt_q + 8'd1;
      end
    end else begin
      lfsr_d = lfsr_q;
    end
    if (accept_s) begin
      aborted_d = 1'b0;
    end else if (abort_s) begin
      aborted_d = 1'b1;
    end else begin
      aborted_d = aborted_q;
    end
    if (check_s) begin
      last_sig_d = misr_q;
      pass_d     = match_s;
      fail_d     = ~match_s;
      count_d    = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    end else begin
      count_d    = count_q;
    end
    // A failing check wins over a simultaneous IRQ_CLR.
    if (check_s && !match_s) begin
      irq_d = 1'b1;
    end else if (irq_clr_s) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  assign status_s = {16'h0000, count_q, 4'h0, aborted_q, fail_q, pass_q, (state_q != IDLE)};

  // APB read mux; unmapped addresses return zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (paddr_i)
      32'h0000_0000: rdata_s = {28'h0000000, auto_q, 2'b00, en_q};
      32'h0000_0004: rdata_s = status_s;
      32'h0000_0008: rdata_s = 32'(seed_q);
      32'h0000_000C: rdata_s = 32'(golden_q);
      32'h0000_0010: rdata_s = 32'(last_sig_q);
      default:       rdata_s = 32'h0000_0000;
    endcase
    if (psel_i && !penable_i && !pwrite_i) begin
      prdata_d = rdata_s;
    end else begin
      prdata_d = prdata_q;
    end
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      seed_q     <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      golden_q   <= {DATA_WIDTH{1'b0}};
      last_sig_q <= {DATA_WIDTH{1'b0}};
      lfsr_q     <= {DATA_WIDTH{1'b0}};
      misr_q     <= {DATA_WIDTH{1'b0}};
      pat_cnt_q  <= 8'd0;
      op_cnt_q   <= 4'd0;
      count_q    <= 8'd0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      aborted_q  <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      auto_q     <= auto_d;
      seed_q     <= seed_d;
      golden_q   <= golden_d;
      last_sig_q <= last_sig_d;
      lfsr_q     <= lfsr_d;
      misr_q     <= misr_d;
      pat_cnt_q  <= pat_cnt_d;
      op_cnt_q   <= op_cnt_d;
      count_q    <= count_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      aborted_q  <= aborted_d;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
    end
  end

endmodule

// File: tb/tb_alu_sig_bist_ctrl.sv
// Directed bench for alu_sig_bist_ctrl: golden ALU + signature model, APB tasks, immediate-assertion checks.
module tb_alu_sig_bist_ctrl;
  localparam logic [31:0] POLY = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_sleep = 1'b0;
  logic        bist_active;
  logic [31:0] op_a, op_b, dut_result;
  logic [3:0]  op_sel;
  logic        sim_fault_inject = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready, error_irq;

  int          checks = 0;
  int          failures = 0;
  int          abort_at = -1;
  int          fault_at = -1;
  logic [31:0] exp_a0;
  logic [31:0] rd, sig_good, sig_exp;
  int          n;

  always #5 clk = ~clk;

  alu_sig_bist_ctrl dut (
    .clk_i(clk), .rst_i(rst), .core_sleep_i(core_sleep),
    .bist_active_o(bist_active), .bist_operand_a_o(op_a), .bist_operand_b_o(op_b),
    .bist_op_sel_o(op_sel), .dut_result_i(dut_result),
`ifdef ALU_SIG_BIST_FAULT_INJECT_EN
    .sim_fault_inject_i(sim_fault_inject),
`endif
    .paddr_i(paddr), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready), .error_irq_o(error_irq)
  );

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign dut_result = alu(op_sel, op_a, op_b);

  // Reference signature over 4 ops x 16 patterns; fidx flips result bit 0 at that pattern index.
  function automatic logic [31:0] model_sig(input logic [31:0] seed, input int fidx);
    logic [31:0] l, m, a, b, r;
    l = (seed == 32'h0) ? 32'h1 : seed;
    m = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) begin
      a = l;
      b = {a[15:0], a[31:16]};
      r = alu(4'(i / 16), a, b);
      if (i == fidx) r = r ^ 32'h1;
      m = {m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0) ^ r;
      l = {l[30:0], 1'b0} ^ (l[31] ? POLY : 32'h0);
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    paddr = addr; pwdata = data; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    data = prdata;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Waits for a RUN burst and counts its active cycles; may abort, inject a fault, or stage a colliding IRQ_CLR.
  task automatic run_session(input bit collide, output int cnt);
    int guard;
    guard = 0;
    cnt = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bist_active && guard < 300);
    chk("session_start_timeout", {31'h0, bist_active}, 32'h1);
    while (bist_active && cnt < 100) begin
      if (cnt == 0) begin
        chk("operand_a_first", op_a, exp_a0);
        chk("operand_b_first", op_b, {exp_a0[15:0], exp_a0[31:16]});
      end
      if ((cnt % 16) == 0 || cnt == 63) chk($sformatf("op_sel_at_%0d", cnt), {28'h0, op_sel}, 32'(cnt / 16));
      sim_fault_inject = (cnt == fault_at);
      if (collide && cnt == 63) begin
        paddr = 32'h0; pwdata = 32'hD; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
      end
      if (cnt == abort_at) begin
        core_sleep = 1'b0;
        #1;
        chk("abort_active_same_cycle", {31'h0, bist_active}, 32'h0);
        return;
      end
      cnt++;
      @(negedge clk);
    end
    sim_fault_inject = 1'b0;
  endtask

  initial begin
    sig_good = model_sig(32'h0000_ACE1, -1);

    // Reset state
    do_reset();
    chk("reset_active", {31'h0, bist_active}, 32'h0);
    chk("reset_irq", {31'h0, error_irq}, 32'h0);
    chk("reset_pready", {31'h0, pready}, 32'h1);
    chk("reset_op_sel", {28'h0, op_sel}, 32'h0);
    chk("reset_operand_a", op_a, 32'h0);
    apb_read(32'h8, rd);  chk("reset_seed", rd, 32'h1);
    apb_read(32'h4, rd);  chk("reset_status", rd, 32'h0);
    apb_write(32'h20, 32'h1234_5678);
    apb_read(32'h20, rd); chk("unmapped_read", rd, 32'h0);

    // Golden pass
    exp_a0 = 32'h0000_ACE1;
    apb_write(32'h8, 32'h0000_ACE1);
    apb_write(32'hC, sig_good);
    apb_read(32'hC, rd); chk("golden_readback", rd, sig_good);
    core_sleep = 1'b1;
    apb_write(32'h0, 32'h3);
    run_session(1'b0, n);
    chk("pass_active_cycles", 32'(n), 32'd64);
    apb_read(32'h4, rd);  chk("pass_status", rd, 32'h0000_0102);
    apb_read(32'h10, rd); chk("pass_last_sig", rd, sig_good);
    chk("pass_no_irq", {31'h0, error_irq}, 32'h0);

    // Fault session
    do_reset();
    apb_write(32'h8, 32'h0000_ACE1);
`ifdef ALU_SIG_BIST_FAULT_INJECT_EN
    apb_write(32'hC, sig_good);
    fault_at = 30;
    sig_exp = model_sig(32'h0000_ACE1, 30);
`else
    apb_write(32'hC, sig_good ^ 32'h1);
    sig_exp = sig_good;
`endif
    apb_write(32'h0, 32'h3);
    run_session(1'b0, n);
    fault_at = -1;
    chk("fault_active_cycles", 32'(n), 32'd64);
    apb_read(32'h4, rd);  chk("fault_status", rd, 32'h0000_0104);
    apb_read(32'h10, rd); chk("fault_last_sig", rd, sig_exp);
    chk("fault_irq_set", {31'h0, error_irq}, 32'h1);
    apb_write(32'h0, 32'h5);
    chk("irq_clr_drops", {31'h0, error_irq}, 32'h0);

    // Abort and restart
    do_reset();
    apb_write(32'h8, 32'h0000_ACE1);
    apb_write(32'hC, sig_good);
    apb_write(32'h0, 32'h3);
    abort_at = 20;
    run_session(1'b0, n);
    abort_at = -1;
    apb_read(32'h4, rd); chk("abort_status", rd, 32'h0000_0009);
    core_sleep = 1'b1;
    run_session(1'b0, n);
    chk("restart_active_cycles", 32'(n), 32'd64);
    apb_read(32'h4, rd);  chk("restart_status", rd, 32'h0000_010A);
    apb_read(32'h10, rd); chk("restart_last_sig", rd, sig_good);

    // AUTO with IRQ_CLR colliding with a failing CHECK
    do_reset();
    apb_write(32'h8, 32'h0000_ACE1);
    apb_write(32'hC, 32'hDEAD_BEEF);
    apb_write(32'h0, 32'hB);
    run_session(1'b1, n);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    chk("collision_irq_kept", {31'h0, error_irq}, 32'h1);
    run_session(1'b0, n);
    chk("auto_second_cycles", 32'(n), 32'd64);
    run_session(1'b0, n);
    apb_read(32'h4, rd);  chk("auto_status_count3", rd, 32'h0000_0305);
    apb_read(32'h10, rd); chk("auto_last_sig", rd, sig_good);
    chk("auto_irq", {31'h0, error_irq}, 32'h1);
    apb_write(32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("en_off_idle", {31'h0, bist_active}, 32'h0);
    apb_read(32'h4, rd); chk("en_off_status", rd, 32'h0000_0304);

    // Zero seed loads as 1
    apb_write(32'h8, 32'h0);
    exp_a0 = 32'h0000_0001;
    apb_write(32'h0, 32'h3);
    run_session(1'b0, n);
    chk("zero_seed_cycles", 32'(n), 32'd64);
    apb_read(32'h10, rd); chk("zero_seed_sig", rd, model_sig(32'h0, -1));

    // Reset in the middle of a session
    apb_write(32'h0, 32'h3);
    repeat (10) @(negedge clk);
    chk("midrun_active", {31'h0, bist_active}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset_active", {31'h0, bist_active}, 32'h0);
    chk("midrun_reset_irq", {31'h0, error_irq}, 32'h0);
    apb_read(32'h4, rd); chk("midrun_reset_status", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_sig_bist_ctrl.md
# alu_sig_bist_ctrl

Parametrised runtime BIST controller for ALU-class datapaths, the next generation of the single-pattern ADD checker. Generates pseudo-random operand pairs from an LFSR, sweeps a configurable number of ALU operations, compacts every result into a MISR signature and compares it with an APB-programmed golden value. It sits between the core's ALU input muxes and the APB safety-register bus, and runs only while the core sleeps.

## Interface
Parameters:
- DATA_WIDTH, 32: operand, result, LFSR and MISR width; must be at least 8.
- NUM_OPS, 4: number of ALU operations swept per session, from 1 to 16.
- PATTERNS_PER_OP, 16: LFSR patterns applied per operation, from 1 to 256.
- LFSR_POLY, 32'h8020_0003: Galois feedback polynomial, shared by the LFSR and the MISR.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous, active-high reset.
- core_sleep_i in 1: core idle. A session may run only while this is high.
- bist_active_o out 1: ALU input muxes select the BIST operands.
- bist_operand_a_o out DATA_WIDTH: LFSR state.
- bist_operand_b_o out DATA_WIDTH: LFSR state rotated left by DATA_WIDTH/2.
- bist_op_sel_o out 4: operation index. The wrapper maps this index to the operator code.
- dut_result_i in DATA_WIDTH: ALU result. The ALU is combinational and its result is valid in the same cycle.
- paddr_i in 32, psel_i in 1, penable_i in 1, pwrite_i in 1, pwdata_i in 32: APB slave inputs.
- prdata_o out 32, pready_o out 1: APB slave outputs.
- error_irq_o out 1: level interrupt on signature mismatch.

## Operation
Registers (word addresses; unmapped addresses read 0 and ignore writes):
- 0x00 CTRL (RW):
  - bit0 EN.
  - bit1 START: write-1 one-shot, self-clears.
  - bit2 IRQ_CLR: write-1, self-clears.
  - bit3 AUTO: restart after each completed session.
- 0x04 STATUS (RO):
  - bit0 BUSY, bit1 PASS, bit2 FAIL, bit3 ABORTED.
  - [15:8] completed-session count, saturating at 255.
- 0x08 SEED (RW): LFSR seed. A zero seed is loaded as 1.
- 0x0C GOLDEN (RW): expected signature.
- 0x10 LAST_SIG (RO): last completed MISR value.

Access rules:
- APB writes commit on psel_i & penable_i & pwrite_i.
- pready_o is constant 1, so there are no wait states.
- prdata_o is registered, valid in the access phase.

FSM states: IDLE, ARMED, RUN, CHECK.
- IDLE → ARMED on START while EN=1.
- ARMED → RUN when core_sleep_i=1. On entry: LFSR ← SEED, MISR ← all-ones, op and pattern counters ← 0.
- RUN, each cycle:
  - MISR ← (MISR<<1) ^ (MISR[MSB] ? LFSR_POLY : 0) ^ dut_result_i.
  - LFSR advances.
  - Pattern counter increments. On wrap from PATTERNS_PER_OP-1, the op counter increments.
  - After NUM_OPS·PATTERNS_PER_OP cycles → CHECK.
- RUN with core_sleep_i=0 → ARMED: set ABORTED and discard partial MISR. The next session restarts from SEED.
- CHECK, one cycle:
  - LAST_SIG ← MISR.
  - PASS/FAIL set according to MISR==GOLDEN, with the opposite flag cleared.
  - Count increments.
  - On FAIL, error_irq_o is set.
  - Next state: ARMED if AUTO=1, else IDLE.
- EN written 0 in any state → IDLE. This does not set ABORTED.

Output and flag rules:
- bist_active_o = (state==RUN) & core_sleep_i (combinational), so the core regains the ALU in the same cycle it wakes.
- bist_op_sel_o holds the op counter. It is 0 outside RUN.
- START while BUSY is ignored.
- ABORTED clears on the next START.
- IRQ_CLR clears error_irq_o. An IRQ_CLR coinciding with a FAIL in CHECK leaves error_irq_o set.

## Timing
- Reset values:
  - All registers 0 except SEED=1.
  - All outputs 0, except pready_o=1.
  - FSM in IDLE.
- START write → ARMED on the next edge. First RUN cycle follows one cycle after core_sleep_i=1 is seen in ARMED.
- Session latency: NUM_OPS·PATTERNS_PER_OP RUN cycles + 1 CHECK cycle. The default is 65 cycles.
- STATUS and error_irq_o update on the edge that leaves CHECK.
- Reset mid-session returns everything to reset values on the next edge.

## Configuration
- ALU_SIG_BIST_FAULT_INJECT_EN defined:
  - Adds input sim_fault_inject_i (1 bit).
  - During RUN, dut_result_i[0] is XORed with sim_fault_inject_i before MISR absorption.
- Undefined: the port does not exist and the MISR absorbs dut_result_i unmodified.

## Test plan
- Reset: after reset, read SEED=0x1, STATUS=0, error_irq_o=0, bist_active_o=0.
- Golden pass:
  - Stimulus: SEED=0xACE1, a golden ALU model in the bench, GOLDEN=model signature, core_sleep_i=1, START.
  - Required: bist_active_o high for exactly 64 cycles; bist_op_sel_o steps 0→3 every 16 cycles; STATUS shows PASS with count=1; LAST_SIG=GOLDEN; no IRQ.
- Fault:
  - Stimulus: same setup with the macro defined; pulse sim_fault_inject_i for 1 cycle mid-RUN.
  - Required: FAIL=1, error_irq_o=1. A following IRQ_CLR write drops error_irq_o.
- Abort:
  - Stimulus: drop core_sleep_i at RUN cycle 20.
  - Required: bist_active_o falls in the same cycle; ABORTED=1. Re-raising core_sleep_i restarts from SEED, and a full 64-cycle session then passes with the same signature.
- AUTO + collision:
  - Stimulus: AUTO=1, GOLDEN wrong, IRQ_CLR written in the CHECK cycle.
  - Required: error_irq_o remains 1 and the count reaches 3 after three sessions.
- Zero seed: SEED=0 → LFSR starts at 1, and operand_a in the first RUN cycle is 0x00000001.
